alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised, handshaked RV32I/M integer execution unit that replaces the purely combinational ALU in the datapath. It accepts a full instruction word plus operand values, decodes R-type (opcode 0110011) and I-type (opcode 0010011) arithmetic/logic ops, and returns a registered result with destination register index. MUL runs as an XLEN-cycle iterative shift-add; all other ops complete in one cycle. Sits between register-file read and writeback.

## Interface
- XLEN, 32, datapath width; legal values 8, 16, 32, 64 (power of two).
- SHW, $clog2(XLEN), shift-amount width (derived, do not override).
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- instr  in  32  RISC-V instruction word.
- rs1_val  in  XLEN  value of register rs1.
- rs2_val  in  XLEN  value of register rs2 (ignored for I-type).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  computed value.
- rd_addr  out  5  instr[11:7] of the accepted instruction.
- illegal  out  1  accepted instruction was not a supported op.

## Operation
- Decode fields: opcode instr[6:0], rd [11:7], funct3 [14:12], funct7 [31:25]; imm = sign-extend(instr[31:20]) to XLEN.
- R-type, funct7 0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7 0100000: 000 SUB, 101 SRA. funct7 0000001, funct3 000: MUL (low XLEN bits of product).
- I-type: 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI; 001 SLLI needs instr[31:25]=0000000; 101 SRLI (0000000) / SRAI (0100000).
- Shift amount = low SHW bits of rs2_val (R) or imm (I); upper bits ignored.
- Add/sub wrap modulo 2^XLEN; SLT/SLTI signed compare, SLTU/SLTIU unsigned; compare results are 0 or 1 zero-extended.
- Any other opcode/funct combination: result=0, illegal=1, one-cycle latency, rd_addr still captured.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid: capture rd, decode; MUL op -> MUL, else register result -> DONE.
  - MUL: multiplicand/multiplier/accumulator registers, counter 0..XLEN-1; each cycle add shifted multiplicand if multiplier LSB set, shift; at count XLEN-1 -> DONE.
  - DONE: out_valid=1, result/rd_addr/illegal stable; on out_ready -> IDLE.
- instr/rs1_val/rs2_val sampled only on the accept edge; later changes have no effect.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, out_valid=0, result=0, rd_addr=0, illegal=0, MUL counter=0. in_ready=0 while rst_n low, 1 on first cycle after release.
- Reset has priority over all other events, including mid-MUL (operation aborted, no output).
- Accept at edge k (in_valid & in_ready): single-cycle op -> out_valid high from edge k+1; MUL -> out_valid high from edge k+XLEN+1.
- out_valid & out_ready at edge j -> out_valid low, in_ready high from edge j+1. Throughput: one op per 2 cycles (single-cycle), XLEN+2 cycles (MUL), with out_ready held high.
- in_ready is a registered state decode; no combinational in->out path.
- out_valid never deasserts without out_ready; outputs hold indefinitely under backpressure.

## Test plan
- ADDI: XLEN=32, instr=0x00338013, rs1_val=7 -> result=10, rd_addr=0, illegal=0, out_valid at k+1.
- SUB / SRA: instr=0x40208033, rs1_val=2, rs2_val=4 -> 0xFFFFFFFE; instr=0x4020D033, rs1_val=0x80000000, rs2_val=0x24 -> 0xF8000000 (only low 5 shift bits used).
- MUL: instr=0x02208033, rs1_val=0x0000FFFF, rs2_val=0x00010001 -> 0xFFFFFFFF, out_valid exactly at k+33, in_ready low k+1..k+33; repeat at XLEN=8 with 0x0F*0x11 -> 0xFF at k+9.
- Backpressure: out_ready low for 5 cycles after out_valid -> result/rd_addr/illegal unchanged, in_ready stays 0, new in_valid ignored; release -> IDLE next cycle.
- Reset mid-MUL: rst_n low at cycle k+10 of a MUL -> out_valid never rises, all outputs 0, next ADD accepted normally after release.
- Illegal: instr=0x0000007F and instr=0xFE001013 (bad SLLI funct7) -> result=0, illegal=1, out_valid at k+1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Handshaked RV32I/M integer execution unit: single-cycle ALU ops plus an
// iterative shift-add multiplier, with a registered result and destination index.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr,
    output logic            illegal
);

    // state | meaning
    // IDLE  | ready for a new instruction
    // MUL   | shift-add multiply in progress, one partial product per cycle
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [SHW-1:0] MUL_LAST = SHW'(XLEN - 1);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_MULDV = 7'b0000001;

    state_t          state, next_state;
    logic            ready_q;
    logic [SHW-1:0]  mul_cnt;
    logic [XLEN-1:0] mcand, mplier, acc, acc_next;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic            is_r, is_i, is_sub, is_sra;
    logic            legal, is_mul, accept;
    logic [XLEN-1:0] imm, opb, alu_res;
    logic [SHW-1:0]  shamt;
    logic            unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign imm    = XLEN'($signed(instr[31:20]));
    assign opb    = is_r ? rs2_val : imm;
    assign shamt  = opb[SHW-1:0];
    assign is_sub = is_r && (funct7 == F7_ALT);
    assign is_sra = (funct7 == F7_ALT);
    assign accept = in_valid && ready_q;
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        legal  = 1'b0;
        is_mul = 1'b0;
        if (is_r) begin
            if (funct7 == F7_BASE) begin
                legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end else if ((funct7 == F7_MULDV) && (funct3 == 3'b000)) begin
                legal  = 1'b1;
                is_mul = 1'b1;
            end
        end else if (is_i) begin
            case (funct3)
                3'b001:  legal = (funct7 == F7_BASE);
                3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = is_sub ? (rs1_val - opb) : (rs1_val + opb);
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = XLEN'($signed(rs1_val) < $signed(opb));
            3'b011:  alu_res = XLEN'(rs1_val < opb);
            3'b100:  alu_res = rs1_val ^ opb;
            3'b101:  alu_res = is_sra ? $unsigned($signed(rs1_val) >>> shamt)
                                      : (rs1_val >> shamt);
            3'b110:  alu_res = rs1_val | opb;
            default: alu_res = rs1_val & opb;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // State register; in_ready is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = is_mul ? S_MUL : S_DONE;
            S_MUL:   if (mul_cnt == MUL_LAST) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == S_DONE);
        in_ready  = ready_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            rd_addr <= '0;
            illegal <= 1'b0;
            mul_cnt <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rd_addr <= instr[11:7];
                        if (is_mul) begin
                            mcand   <= rs1_val;
                            mplier  <= rs2_val;
                            acc     <= '0;
                            mul_cnt <= '0;
                            illegal <= 1'b0;
                        end else begin
                            result  <= legal ? alu_res : '0;
                            illegal <= ~legal;
                        end
                    end
                end
                S_MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + SHW'(1);
                    if (mul_cnt == MUL_LAST) result <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule
